// File: rtl/irq_seq_if.sv
// irq_seq_if: control-unit / register-file / memory-bus signals of the interrupt sequencer
interface irq_seq_if #(parameter int NUM_IRQ = 8);
  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_ack;
  logic instr_done;
  logic reti;
  logic [15:0] pc_q;
  logic [15:0] sp_q;
  logic [15:0] sr_q;
  logic [15:0] mem_rdata;
  logic mem_ready;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic mem_we;
  logic mem_re;
  logic rf_RW;
  logic [3:0] rf_DA;
  logic [15:0] rf_Din;
  logic cpu_stall;
  modport master (
    input irq, instr_done, reti, pc_q, sp_q, sr_q, mem_rdata, mem_ready,
    output mem_addr, mem_wdata, mem_we, mem_re, rf_RW, rf_DA, rf_Din, irq_ack, cpu_stall
  );
  modport slave (
    output irq, instr_done, reti, pc_q, sp_q, sr_q, mem_rdata, mem_ready,
    input mem_addr, mem_wdata, mem_we, mem_re, rf_RW, rf_DA, rf_Din, irq_ack, cpu_stall
  );
endinterface

// File: rtl/irq_seq.sv
// irq_seq: MSP430 interrupt entry / RETI sequencer owning the register write port and memory port
module irq_seq #(
  parameter int NUM_IRQ = 8,
  parameter logic [15:0] VEC_BASE = 16'hFFE0
) (
  input logic clk,
  input logic rst,
  irq_seq_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, SP_DEC1, PUSH_PC, SP_DEC2, PUSH_SR, CLR_SR, RD_VEC, LOAD_PC,
    POP_SR, SP_INC1, POP_PC, SP_INC2
  } state_t;
  localparam int KW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;
  state_t r_state, w_next;
  logic [KW-1:0] r_k, w_k;
  logic [15:0] r_vec;
  logic [NUM_IRQ-1:0] r_ack;
  logic w_take;
  always_comb begin
    w_k = '0;
    for (int i = 0; i < NUM_IRQ; i++) if (bus.irq[i]) w_k = KW'(i);
  end
  assign w_take = r_state == IDLE && bus.instr_done && !bus.reti && bus.sr_q[3] && |bus.irq;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_k <= '0;
      r_vec <= '0;
      r_ack <= '0;
    end else begin
      r_state <= w_next;
      r_ack <= w_take ? NUM_IRQ'(1) << w_k : '0;
      if (w_take) r_k <= w_k;
      if (r_state == RD_VEC && bus.mem_ready) r_vec <= bus.mem_rdata;
    end
  end
  always_comb begin
    w_next = r_state;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    bus.mem_we = 1'b0;
    bus.mem_re = 1'b0;
    bus.rf_RW = 1'b0;
    bus.rf_DA = '0;
    bus.rf_Din = '0;
    case (r_state)
      IDLE: w_next = (bus.instr_done && bus.reti) ? POP_SR : w_take ? SP_DEC1 : IDLE;
      SP_DEC1, SP_DEC2: begin
        bus.rf_RW = 1'b1;
        bus.rf_DA = 4'd1;
        bus.rf_Din = bus.sp_q - 16'd2;
        w_next = r_state == SP_DEC1 ? PUSH_PC : PUSH_SR;
      end
      PUSH_PC, PUSH_SR: begin
        bus.mem_we = 1'b1;
        bus.mem_addr = bus.sp_q;
        bus.mem_wdata = r_state == PUSH_PC ? bus.pc_q : bus.sr_q;
        if (bus.mem_ready) w_next = r_state == PUSH_PC ? SP_DEC2 : CLR_SR;
      end
      CLR_SR: begin
        bus.rf_RW = 1'b1;
        bus.rf_DA = 4'd2;
        bus.rf_Din = bus.sr_q & 16'h0040;
        w_next = RD_VEC;
      end
      RD_VEC: begin
        bus.mem_re = 1'b1;
        bus.mem_addr = VEC_BASE + 16'({r_k, 1'b0});
        if (bus.mem_ready) w_next = LOAD_PC;
      end
      LOAD_PC: begin
        bus.rf_RW = 1'b1;
        bus.rf_DA = 4'd0;
        bus.rf_Din = r_vec;
        w_next = IDLE;
      end
      POP_SR, POP_PC: begin
        bus.mem_re = 1'b1;
        bus.mem_addr = bus.sp_q;
        bus.rf_RW = bus.mem_ready;
        bus.rf_DA = (bus.mem_ready && r_state == POP_SR) ? 4'd2 : 4'd0;
        bus.rf_Din = bus.mem_ready ? bus.mem_rdata : 16'h0000;
        if (bus.mem_ready) w_next = r_state == POP_SR ? SP_INC1 : SP_INC2;
      end
      SP_INC1, SP_INC2: begin
        bus.rf_RW = 1'b1;
        bus.rf_DA = 4'd1;
        bus.rf_Din = bus.sp_q + 16'd2;
        w_next = r_state == SP_INC1 ? POP_PC : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  assign bus.cpu_stall = r_state != IDLE;
  assign bus.irq_ack = r_ack;
endmodule
